// File: rtl/pipeline_stall_controller_if.sv
// pipeline_stall_controller_if: stall/flush control bundle between ID-stage hazard sources and the pipeline sequencer
interface pipeline_stall_controller_if;
  logic        hz_load_stall;
  logic        branch_taken;
  logic        md_start;
  logic        md_read;
  logic        pc_enable;
  logic        ifid_enable;
  logic        ifid_flush;
  logic        idex_nop;
  logic        md_issue;
  logic        md_busy;
  logic        md_done;
  logic [15:0] stall_count;
  modport master (
    output hz_load_stall, branch_taken, md_start, md_read,
    input  pc_enable, ifid_enable, ifid_flush, idex_nop, md_issue, md_busy, md_done, stall_count
  );
  modport slave (
    input  hz_load_stall, branch_taken, md_start, md_read,
    output pc_enable, ifid_enable, ifid_flush, idex_nop, md_issue, md_busy, md_done, stall_count
  );
endinterface

// File: rtl/pipeline_stall_controller.sv
// pipeline_stall_controller: merges load-use, branch and MULT/DIV hazards into PC/IF/ID/ID/EX strobes; PIPE_DELAY_SLOT_EN keeps the branch delay slot
module pipeline_stall_controller #(
  parameter int MD_LATENCY = 32,
  parameter int CNT_W      = 6
) (
  input  logic                        clk,
  input  logic                        reset,
  pipeline_stall_controller_if.slave  bus
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t           state;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic             md_done_q, md_done_d;
  logic [15:0]      stall_count_q, stall_count_d;
  logic             md_stall, stall;
  // HI/LO occupancy state, stall merging with priority, and next-state of all registers
  always_comb begin
    state         = (md_cnt_q != '0) ? BUSY : IDLE;
    md_stall      = (state == BUSY) & (bus.md_start | bus.md_read);
    stall         = md_stall | bus.hz_load_stall;
    bus.pc_enable   = ~reset & ~stall;
    bus.ifid_enable = ~reset & ~stall;
    bus.idex_nop    = reset | stall;
`ifdef PIPE_DELAY_SLOT_EN
    bus.ifid_flush  = 1'b0;
`else
    bus.ifid_flush  = ~reset & ~stall & bus.branch_taken;
`endif
    bus.md_issue    = ~reset & (state == IDLE) & bus.md_start & ~bus.hz_load_stall;
    bus.md_busy     = (state == BUSY);
    bus.md_done     = md_done_q;
    bus.stall_count = stall_count_q;
    md_cnt_d      = bus.md_issue ? CNT_W'(MD_LATENCY) : (state == BUSY) ? md_cnt_q - 1'b1 : '0;
    md_done_d     = (md_cnt_q == CNT_W'(1));
    stall_count_d = (~bus.pc_enable && stall_count_q != 16'hFFFF) ? stall_count_q + 16'd1 : stall_count_q;
  end
  // Register update; reset aborts any MULT/DIV in flight so no done pulse follows
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      md_cnt_q      <= '0;
      md_done_q     <= 1'b0;
      stall_count_q <= '0;
    end else begin
      md_cnt_q      <= md_cnt_d;
      md_done_q     <= md_done_d;
      stall_count_q <= stall_count_d;
    end
  end
endmodule
